// File: rtl/stream_to_packed_array.sv
// stream_to_packed_array
// Collects BIT_WIDTH-wide elements from a valid/ready stream into a COLS-wide
// packed row and presents the row on a valid/ready output stream. Rows may be
// closed early by in_last; unfilled columns read PAD_VALUE and out_count
// reports how many columns hold real data. Column 0 sits in the LSBs.

// Protocol checker: observes the block's ports and flags protocol breaches.
module stream_to_packed_array_chk #(
    parameter int COLS = 8,
    parameter int DW   = 32,
    parameter int CW   = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          in_valid,
    input logic          in_ready,
    input logic          out_valid,
    input logic          out_ready,
    input logic [DW-1:0] out_data,
    input logic [CW-1:0] out_count,
    input logic          out_last
);

    // Input ready must follow the output side without any register in between.
    a_in_ready: assert property (@(posedge clk)
        in_ready == (!out_valid || out_ready));

    // A held row must not change until the consumer accepts it.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_count) && $stable(out_last)));

    // A presented row always carries between 1 and COLS real columns.
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> ((out_count >= CW'(1'b1)) && (out_count <= CW'(COLS))));

    // With no row presented the side-band outputs sit at their idle values.
    a_idle_clean: assert property (@(posedge clk) disable iff (rst)
        !out_valid |-> ((out_count == {CW{1'b0}}) && !out_last));

    // A held row blocks the input stream entirely.
    a_no_accept_in_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |-> !(in_valid && in_ready));

endmodule

module stream_to_packed_array #(
    parameter int                   BIT_WIDTH = 4,
    parameter int                   COLS      = 8,
    parameter logic [BIT_WIDTH-1:0] PAD_VALUE = {BIT_WIDTH{1'b0}},
    localparam int                  CW        = $clog2(COLS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BIT_WIDTH-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    output logic [COLS*BIT_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW-1:0]             out_count,
    output logic                      out_last
);

    localparam int            IW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(COLS - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                state_r;
    logic [IW-1:0]         idx_r;
    logic [BIT_WIDTH-1:0]  row_r [COLS];
    logic                  out_valid_r;
    logic [CW-1:0]         out_count_r;
    logic                  out_last_r;

    logic                      in_ready_s;
    logic                      in_beat_s;
    logic                      out_beat_s;
    logic [IW-1:0]             wr_idx_s;
    logic [CW-1:0]             wr_count_s;
    logic                      close_s;
    logic [COLS*BIT_WIDTH-1:0] out_data_s;

    // Handshake qualification; in_ready stays combinational for full throughput.
    always_comb begin
        in_ready_s = !out_valid_r || out_ready;
        in_beat_s  = in_valid && in_ready_s;
        out_beat_s = out_valid_r && out_ready;
    end

    // Column that an accepted element lands in and whether it closes the row.
    always_comb begin
        if (state_r == ST_HOLD) begin
            // An element accepted while a row is held starts the next row.
            wr_idx_s = {IW{1'b0}};
        end else begin
            wr_idx_s = idx_r;
        end
        wr_count_s = CW'(wr_idx_s) + CW'(1'b1);
        close_s    = in_beat_s && ((wr_idx_s == LAST_IDX) || in_last);
    end

    // Fill/hold controller owning the row buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FILL;
            idx_r       <= {IW{1'b0}};
            out_valid_r <= 1'b0;
            out_count_r <= {CW{1'b0}};
            out_last_r  <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                row_r[i] <= PAD_VALUE;
            end
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_beat_s) begin
                        row_r[wr_idx_s] <= in_data;
                        if (close_s) begin
                            state_r     <= ST_HOLD;
                            out_valid_r <= 1'b1;
                            out_count_r <= wr_count_s;
                            out_last_r  <= in_last;
                            idx_r       <= {IW{1'b0}};
                        end else begin
                            idx_r <= idx_r + IW'(1'b1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_beat_s) begin
                        // Row handed off: re-pad the buffer before any new write.
                        for (int i = 0; i < COLS; i++) begin
                            row_r[i] <= PAD_VALUE;
                        end
                        if (in_beat_s) begin
                            row_r[wr_idx_s] <= in_data;
                            if (close_s) begin
                                state_r     <= ST_HOLD;
                                out_valid_r <= 1'b1;
                                out_count_r <= wr_count_s;
                                out_last_r  <= in_last;
                                idx_r       <= {IW{1'b0}};
                            end else begin
                                state_r     <= ST_FILL;
                                out_valid_r <= 1'b0;
                                out_count_r <= {CW{1'b0}};
                                out_last_r  <= 1'b0;
                                idx_r       <= wr_idx_s + IW'(1'b1);
                            end
                        end else begin
                            state_r     <= ST_FILL;
                            out_valid_r <= 1'b0;
                            out_count_r <= {CW{1'b0}};
                            out_last_r  <= 1'b0;
                            idx_r       <= {IW{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r     <= ST_FILL;
                    idx_r       <= {IW{1'b0}};
                    out_valid_r <= 1'b0;
                    out_count_r <= {CW{1'b0}};
                    out_last_r  <= 1'b0;
                    for (int i = 0; i < COLS; i++) begin
                        row_r[i] <= PAD_VALUE;
                    end
                end
            endcase
        end
    end

    // Flatten the row registers, column 0 in the least significant bits.
    always_comb begin
        out_data_s = {(COLS*BIT_WIDTH){1'b0}};
        for (int i = 0; i < COLS; i++) begin
            out_data_s[i*BIT_WIDTH +: BIT_WIDTH] = row_r[i];
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_s;
    assign out_valid = out_valid_r;
    assign out_count = out_count_r;
    assign out_last  = out_last_r;

    stream_to_packed_array_chk #(
        .COLS (COLS),
        .DW   (COLS*BIT_WIDTH),
        .CW   (CW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .out_count (out_count_r),
        .out_last  (out_last_r)
    );

endmodule

// File: tb/tb_stream_to_packed_array.sv
// Bench for stream_to_packed_array: two instances (pad 0 and pad F) share the
// stimulus; a row-level reference model built from element queues predicts
// handshakes and every presented row.
module tb_stream_to_packed_array;

    localparam int COLS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_data = 4'h0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_last_a;
    logic [31:0] out_data_a;
    logic [3:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [31:0] out_data_b;
    logic [3:0]  out_count_b;

    // Reference model: elements of the row being filled, and the presented row.
    logic [3:0]  cur_row[$];
    logic [3:0]  held_row[$];
    bit          held_v;
    bit          held_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_to_packed_array #(.BIT_WIDTH(4), .COLS(8), .PAD_VALUE(4'h0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_last(in_last), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a),
        .out_last(out_last_a)
    );

    stream_to_packed_array #(.BIT_WIDTH(4), .COLS(8), .PAD_VALUE(4'hF)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_last(in_last), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b),
        .out_last(out_last_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_held(input logic [3:0] pad);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < COLS; i++) begin
            if (i < held_row.size()) r[i*4 +: 4] = held_row[i];
            else                     r[i*4 +: 4] = pad;
        end
        return r;
    endfunction

    // One clock cycle: drive, check against the model, clock, update the model.
    task automatic cycle(input bit v, input logic [3:0] d, input bit l, input bit r);
        bit exp_ir, ib, ob;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        exp_ir = !held_v || r;
        check_eq("in_ready_a", 64'(in_ready_a), 64'(exp_ir));
        check_eq("in_ready_b", 64'(in_ready_b), 64'(exp_ir));
        check_eq("out_valid_a", 64'(out_valid_a), 64'(held_v));
        check_eq("out_valid_b", 64'(out_valid_b), 64'(held_v));
        if (held_v) begin
            check_eq("out_data_a", 64'(out_data_a), 64'(pack_held(4'h0)));
            check_eq("out_data_b", 64'(out_data_b), 64'(pack_held(4'hF)));
            check_eq("out_count", 64'(out_count_a), 64'(held_row.size()));
            check_eq("out_last", 64'(out_last_a), 64'(held_last));
        end else begin
            check_eq("idle_count", 64'(out_count_a), 64'(0));
            check_eq("idle_last", 64'(out_last_a), 64'(0));
        end
        ib = v && exp_ir;
        ob = held_v && r;
        @(posedge clk);
        #1;
        if (ob) begin
            held_v = 1'b0;
            held_row.delete();
        end
        if (ib) begin
            cur_row.push_back(d);
            if ((cur_row.size() == COLS) || l) begin
                held_row  = cur_row;
                held_last = l;
                held_v    = 1'b1;
                cur_row.delete();
            end
        end
    endtask

    // Reset with busy inputs to show reset overrides them, then check idle state.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 4'h7;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_row.delete();
        held_row.delete();
        held_v    = 1'b0;
        held_last = 1'b0;
        check_eq("rst_out_valid", 64'(out_valid_a), 64'(0));
        check_eq("rst_out_count", 64'(out_count_a), 64'(0));
        check_eq("rst_out_last", 64'(out_last_a), 64'(0));
        check_eq("rst_data_a", 64'(out_data_a), 64'h0);
        check_eq("rst_data_b", 64'(out_data_b), 64'hFFFF_FFFF);
        check_eq("rst_in_ready", 64'(in_ready_a), 64'(1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Full row 1..8.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1);
        check_eq("row8_valid", 64'(out_valid_a), 64'(1));
        check_eq("row8_data", 64'(out_data_a), 64'h8765_4321);
        check_eq("row8_count", 64'(out_count_a), 64'(8));
        check_eq("row8_last", 64'(out_last_a), 64'(0));
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Short row A,B,C closed by in_last.
        cycle(1'b1, 4'hA, 1'b0, 1'b1);
        cycle(1'b1, 4'hB, 1'b0, 1'b1);
        cycle(1'b1, 4'hC, 1'b1, 1'b1);
        check_eq("short_data_a", 64'(out_data_a), 64'h0000_0CBA);
        check_eq("short_data_b", 64'(out_data_b), 64'hFFFF_FCBA);
        check_eq("short_count", 64'(out_count_a), 64'(3));
        check_eq("short_last", 64'(out_last_a), 64'(1));
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // in_last on the 8th element.
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 3), (i == 7), 1'b1);
        check_eq("full_last_count", 64'(out_count_a), 64'(8));
        check_eq("full_last_last", 64'(out_last_a), 64'(1));
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Full throughput: 24 back-to-back elements.
        for (int i = 0; i < 24; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Backpressure for 5 cycles after a full row, then release.
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(15 - i), 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 4'h9, 1'b0, 1'b0);
        cycle(1'b1, 4'h5, 1'b1, 1'b1);
        check_eq("bp_data", 64'(out_data_a), 64'h0000_0005);
        check_eq("bp_count", 64'(out_count_a), 64'(1));
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Single-element rows back to back.
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 1), 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Reset mid-row, then a clean row from column 0.
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'hE, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(8 - i), 1'b0, 1'b1);
        check_eq("post_rst_data", 64'(out_data_a), 64'h1234_5678);

        // Reset mid-hold.
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 2), 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
